main_mem_model: RTL and testbench
=================================

// Module: main_mem_model
// PURPOSE
//  Next-level memory model on the L1 miss path, directly downstream of the set-associative lookup stage.
//  - Accepts one block-fill request per miss.
//  - Waits a modelled access latency, then returns a full cache block built deterministically from the address.
//  - Reports the measured miss latency and a count of serviced requests for the ILA / statistics path.
// PARAMETERS
//  BLOCK_SIZE_BYTE  16  bytes per block; power of two, 4..64; block width = BLOCK_SIZE_BYTE*8
//  ADDR_W           32  request address width
//  BASE_LATENCY     10  cycles from acceptance to resp_valid; legal 1..28
//  OFFSET_W  (local)    log2(BLOCK_SIZE_BYTE)
// PORTS
//  clk          in   1                   system clock, rising edge
//  rst          in   1                   synchronous, active-high reset
//  req_valid    in   1                   miss request present
//  req_addr     in   ADDR_W              miss address; offset bits ignored
//  req_ready    out  1                   model idle, can accept a request
//  resp_valid   out  1                   block on resp_block is valid
//  resp_ready   in   1                   consumer takes the block
//  resp_block   out  BLOCK_SIZE_BYTE*8   fill data; word 0 in bits [31:0]
//  miss_latency out  5                   cycles of the last request, acceptance to resp_valid
//  req_count    out  16                  number of completed responses
// BEHAVIOUR
//  Reset:
//  - State IDLE; req_ready=1; resp_valid=0; resp_block=0; miss_latency=0; req_count=0.
//  - Reset mid-WAIT or mid-RESP abandons the request; no response is produced.
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//  - IDLE: req_ready=1. On req_valid, latch blk_addr = {req_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}, load lat_cnt=1, go to WAIT.
//  - WAIT: req_ready=0. lat_cnt increments each cycle. When lat_cnt==LAT, go to RESP, where LAT = BASE_LATENCY (+ jitter).
//  - RESP: resp_valid=1, data stable, held until resp_ready=1. On that edge, req_count+1 (wraps 16'hFFFF->0) and go to IDLE.
//  Latency:
//  - Request accepted at edge N; resp_valid first high in the cycle after edge N+LAT.
//  - The RESP->IDLE bubble makes the minimum spacing between acceptances LAT+2 cycles.
//  Data:
//  - 32-bit word i (i = 0..BLOCK_SIZE_BYTE/4-1) = blk_addr + 4*i, i.e. the word's own byte address.
//  - ADDR_W<32 is zero-extended; sums are truncated to 32 bits (wrap at 2^32).
//  miss_latency:
//  - Written on the WAIT->RESP edge with LAT, saturated at 31.
//  - Holds until the next WAIT->RESP transition.
//  Boundaries:
//  - req_valid in WAIT/RESP is ignored. Consumer must hold it and retry in IDLE.
//  - req_valid high in the same cycle as the resp_ready handshake is not accepted; it is taken in the following IDLE cycle.
//  - resp_ready while not in RESP has no effect.
//  - BASE_LATENCY outside 1..28 is illegal: simulation $error at time 0.
// CONFIGURATION
//  MEM_JITTER_EN defined:
//  - 8-bit LFSR, taps x^8+x^6+x^5+x^4+1, reset value 8'hA5.
//  - LFSR advances once per accepted request.
//  - LAT = BASE_LATENCY + lfsr[1:0], sampled at acceptance (0..3 extra cycles).
//  MEM_JITTER_EN undefined:
//  - No LFSR logic; LAT = BASE_LATENCY exactly.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> req_ready=1, resp_valid=0, miss_latency=0, req_count=0.
//  2. Single miss, defaults:
//     - Stimulus: req_addr=32'h0000_1234 at edge N, resp_ready=1.
//     - Required: resp_valid high after edge N+10; resp_block={32'h123C,32'h1238,32'h1234,32'h1230}; miss_latency=10; req_count=1.
//  3. Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_block stable; req_count is incremented only on the handshake edge.
//  4. Busy request: second req_valid asserted during WAIT -> ignored; accepted in the first IDLE cycle after the handshake; two responses in order; req_count=2.
//  5. Reset mid-WAIT: rst pulse at cycle 5 -> no resp_valid ever; req_count=0; next request serviced normally.
//  6. MEM_JITTER_EN: 8 back-to-back requests -> each miss_latency in 10..13 and matches the LFSR reference model sequence from seed 8'hA5.

Source files
------------

// File: rtl/main_mem_model.sv
// Next-level memory model: one block fill per miss after a fixed (optionally jittered) latency.
// Optional MEM_JITTER_EN adds 0..3 LFSR-driven cycles to each access.
module main_mem_model #(
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ADDR_W          = 32,
  parameter int BASE_LATENCY    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [BLOCK_SIZE_BYTE*8-1:0] resp_block,
  output logic [4:0]                   miss_latency,
  output logic [15:0]                  req_count
);
  localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE);
  localparam int BLOCK_W  = BLOCK_SIZE_BYTE * 8;
  localparam int WORDS    = BLOCK_SIZE_BYTE / 4;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  if (BASE_LATENCY < 1 || BASE_LATENCY > 28) begin : g_bad_latency
    $error("main_mem_model: BASE_LATENCY %0d outside 1..28", BASE_LATENCY);
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  blk_addr;
  logic [4:0]         lat_cnt;
  logic [4:0]         lat;
  logic [4:0]         lat_next;
  logic [31:0]        base;
  logic [BLOCK_W-1:0] fill;
  logic               accept;

  assign accept = (state == S_IDLE) && req_valid;

`ifdef MEM_JITTER_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  // Fibonacci form of x^8+x^6+x^5+x^4+1; stepped once per accepted miss.
  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign lat_next = 5'(BASE_LATENCY) + {3'b000, lfsr[1:0]};

  always_ff @(posedge clk) begin
    if (rst)         lfsr <= 8'hA5;
    else if (accept) lfsr <= {lfsr[6:0], lfsr_fb};
  end
`else
  assign lat_next = 5'(BASE_LATENCY);
`endif

  // Each 32-bit word carries its own byte address.
  always_comb begin
    base = 32'(blk_addr);
    fill = '0;
    for (int i = 0; i < WORDS; i++) begin
      fill[i*32 +: 32] = base + 32'(4 * i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_block   <= '0;
      miss_latency <= '0;
      req_count    <= '0;
      blk_addr     <= '0;
      lat_cnt      <= '0;
      lat          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            blk_addr  <= req_addr & ~OFFSET_MASK;
            lat       <= lat_next;
            lat_cnt   <= 5'd1;
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == lat) begin
            resp_valid   <= 1'b1;
            resp_block   <= fill;
            miss_latency <= lat;
            state        <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt + 5'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            req_count  <= req_count + 16'd1;
            state      <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_main_mem_model.sv
// Directed bench for main_mem_model; jitter checks compile in when MEM_JITTER_EN is defined.
module tb_main_mem_model;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [BW-1:0] resp_block;
  logic [4:0]    miss_latency;
  logic [15:0]   req_count;

  int checks = 0;
  int errors = 0;
  int cyc;
  int seen;

  main_mem_model dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_block(resp_block),
    .miss_latency(miss_latency), .req_count(req_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles until resp_valid is seen; 99 on timeout so the caller's check fails.
  task automatic wait_resp(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (resp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // 1. Reset
    do_reset();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_miss_latency", miss_latency, 0);
    check("rst_req_count", req_count, 0);
    check("rst_resp_block", resp_block, 0);

    // 2. Single miss
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_1234;
    tick();
    req_valid = 1'b0;
    check("t2_busy", req_ready, 0);
    wait_resp(cyc);
    check("t2_latency_cycles", cyc, 10);
    check("t2_block", resp_block, {32'h123C, 32'h1238, 32'h1234, 32'h1230});
    check("t2_miss_latency", miss_latency, 10);
    tick();
    check("t2_req_count", req_count, 1);
    check("t2_resp_valid_low", resp_valid, 0);
    check("t2_req_ready", req_ready, 1);

    // 3. Backpressure
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0000_ABCF;
    tick();
    req_valid = 1'b0;
    wait_resp(cyc);
    check("t3_latency_cycles", cyc, 10);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", resp_valid, 1);
      check("t3_hold_block", resp_block, {32'hABCC, 32'hABC8, 32'hABC4, 32'hABC0});
      check("t3_hold_count", req_count, 1);
    end
    resp_ready = 1'b1;
    tick();
    check("t3_req_count", req_count, 2);
    check("t3_resp_valid_low", resp_valid, 0);

    // 4. Request while busy
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t4_wait_busy", req_ready, 0);
    req_valid = 1'b1;
    req_addr  = 32'h0000_2008;
    wait_resp(cyc);
    check("t4_a_latency", cyc, 7);
    check("t4_a_block", resp_block, {32'h010C, 32'h0108, 32'h0104, 32'h0100});
    tick();
    check("t4_a_count", req_count, 1);
    check("t4_idle_ready", req_ready, 1);
    tick();
    check("t4_b_accepted", req_ready, 0);
    req_valid = 1'b0;
    wait_resp(cyc);
    check("t4_b_latency", cyc, 10);
    check("t4_b_block", resp_block, {32'h200C, 32'h2008, 32'h2004, 32'h2000});
    tick();
    check("t4_req_count", req_count, 2);

    // 5. Reset mid-WAIT
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0000_4440;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req_ready", req_ready, 1);
    check("t5_req_count", req_count, 0);
    check("t5_miss_latency", miss_latency, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    check("t5_no_response", seen, 0);
    req_valid = 1'b1;
    req_addr  = 32'hFFFF_FFF7;
    tick();
    req_valid = 1'b0;
    wait_resp(cyc);
    check("t5_latency", cyc, 10);
    check("t5_block", resp_block, {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0});
    tick();
    check("t5_req_count_after", req_count, 1);

`ifdef MEM_JITTER_EN
    // 6. Jitter sequence against a reference LFSR from seed 8'hA5
    begin
      logic [7:0] ref_lfsr;
      int         exp_lat;
      ref_lfsr = 8'hA5;
      do_reset();
      req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        req_addr = 32'h0001_0000 + 32'(k * 16);
        tick();
        exp_lat = 10 + int'(ref_lfsr[1:0]);
        ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
        wait_resp(cyc);
        check("t6_latency_cycles", cyc, exp_lat);
        check("t6_miss_latency", miss_latency, exp_lat);
        tick();
      end
      req_valid = 1'b0;
      check("t6_req_count", req_count, 8);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
